// File: rtl/priority_resolver_in_service.sv
// Priority resolver and in-service register: masks pending requests, picks the
// top-priority level under rotation, drives INT and sequences the two-pulse INTA.
module priority_resolver_in_service (
  input  logic       clock,
  input  logic       write_initial_command_word_1_reset,
  input  logic [7:0] interrupt_request_register,
  input  logic [7:0] interrupt_mask,
  input  logic       special_mask_mode,
  input  logic       auto_eoi_config,
  input  logic       auto_rotate_mode,
  input  logic       ocw2_write,
  input  logic [7:0] ocw2_data,
  input  logic       interrupt_acknowledge_n,
  output logic       interrupt_to_cpu,
  output logic [7:0] clear_interrupt_request,
  output logic       freeze,
  output logic [7:0] in_service_register,
  output logic [2:0] acknowledged_level
);

  localparam int unsigned NUM_LEVELS = 8;
  localparam int unsigned LEVEL_W    = 3;

  typedef enum logic [1:0] {IDLE, ACK1, GAP, ACK2} state_t;

  state_t               state, nxt_state;
  logic                 inta_q;
  logic                 spurious, nxt_spurious;
  logic [LEVEL_W-1:0]   lowest_priority, nxt_lowest_priority;
  logic [NUM_LEVELS-1:0] nxt_isr, isr_set, isr_clr, nxt_clear;
  logic [LEVEL_W-1:0]   nxt_ack_level;
  logic                 nxt_int, nxt_freeze;

  logic [NUM_LEVELS-1:0] eligible;
  logic                 winner_valid, blocked, isr_top_valid;
  logic [LEVEL_W-1:0]   winner, isr_top, scan_level;
  logic                 inta_fall, inta_rise, first_fall, second_rise;
  logic [2:0]           ocw2_cmd;
  logic [LEVEL_W-1:0]   ocw2_level;

  assign eligible    = interrupt_request_register & ~interrupt_mask & ~in_service_register;
  assign inta_fall   = inta_q & ~interrupt_acknowledge_n;
  assign inta_rise   = ~inta_q & interrupt_acknowledge_n;
  assign first_fall  = (state == IDLE) && inta_fall;
  assign second_rise = (state == ACK2) && inta_rise;
  assign ocw2_cmd    = ocw2_data[7:5];
  assign ocw2_level  = ocw2_data[2:0];

  // Scan levels from highest priority down; in normal mode an in-service bit stops the scan.
  always_comb begin
    winner_valid  = 1'b0;
    winner        = '0;
    blocked       = 1'b0;
    isr_top_valid = 1'b0;
    isr_top       = '0;
    scan_level    = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      scan_level = lowest_priority + LEVEL_W'(i + 1);
      if (!winner_valid && !blocked) begin
        if (eligible[scan_level]) begin
          winner_valid = 1'b1;
          winner       = scan_level;
        end else if (in_service_register[scan_level] && !special_mask_mode) begin
          blocked = 1'b1;
        end
      end
      if (!isr_top_valid && in_service_register[scan_level]) begin
        isr_top_valid = 1'b1;
        isr_top       = scan_level;
      end
    end
  end

  // Next-state, ISR update, rotation and registered output values.
  always_comb begin
    nxt_state           = state;
    nxt_lowest_priority = lowest_priority;
    nxt_spurious        = spurious;
    nxt_ack_level       = acknowledged_level;
    isr_clr             = '0;
    isr_set             = '0;
    nxt_clear           = '0;
    nxt_int             = interrupt_to_cpu;

    unique case (state)
      IDLE:    if (inta_fall) nxt_state = ACK1;
      ACK1:    if (inta_rise) nxt_state = GAP;
      GAP:     if (inta_fall) nxt_state = ACK2;
      ACK2:    if (inta_rise) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase

    if (first_fall) begin
      nxt_int       = 1'b0;
      nxt_spurious  = !winner_valid;
      nxt_ack_level = winner_valid ? winner : LEVEL_W'(NUM_LEVELS - 1);
      if (winner_valid) begin
        isr_set   = NUM_LEVELS'(1) << winner;
        nxt_clear = NUM_LEVELS'(1) << winner;
      end
    end else if (state == IDLE) begin
      nxt_int = winner_valid;
    end

    if (second_rise && auto_eoi_config && !spurious) begin
      isr_clr = NUM_LEVELS'(1) << acknowledged_level;
      if (auto_rotate_mode) nxt_lowest_priority = acknowledged_level;
    end

    // OCW2 is applied after auto-rotate so an explicit rotate overrides it.
    if (ocw2_write) begin
      unique case (ocw2_cmd)
        3'b001: if (isr_top_valid) isr_clr = isr_clr | (NUM_LEVELS'(1) << isr_top);
        3'b011: isr_clr = isr_clr | (NUM_LEVELS'(1) << ocw2_level);
        3'b101: if (isr_top_valid) begin
          isr_clr             = isr_clr | (NUM_LEVELS'(1) << isr_top);
          nxt_lowest_priority = isr_top;
        end
        3'b111: begin
          isr_clr             = isr_clr | (NUM_LEVELS'(1) << ocw2_level);
          nxt_lowest_priority = ocw2_level;
        end
        3'b110:  nxt_lowest_priority = ocw2_level;
        default: ;
      endcase
    end

    nxt_isr    = (in_service_register & ~isr_clr) | isr_set;
    nxt_freeze = (nxt_state != IDLE);
  end

  always_ff @(posedge clock) begin
    if (write_initial_command_word_1_reset) begin
      state                   <= IDLE;
      inta_q                  <= 1'b1;
      spurious                <= 1'b0;
      lowest_priority         <= LEVEL_W'(NUM_LEVELS - 1);
      in_service_register     <= '0;
      acknowledged_level      <= '0;
      clear_interrupt_request <= '0;
      interrupt_to_cpu        <= 1'b0;
      freeze                  <= 1'b0;
    end else begin
      state                   <= nxt_state;
      inta_q                  <= interrupt_acknowledge_n;
      spurious                <= nxt_spurious;
      lowest_priority         <= nxt_lowest_priority;
      in_service_register     <= nxt_isr;
      acknowledged_level      <= nxt_ack_level;
      clear_interrupt_request <= nxt_clear;
      interrupt_to_cpu        <= nxt_int;
      freeze                  <= nxt_freeze;
    end
  end

endmodule

// File: tb/tb_priority_resolver_in_service.sv
// Directed bench for priority_resolver_in_service with hand-computed expectations.
module tb_priority_resolver_in_service;

  logic       clock = 1'b0;
  logic       write_initial_command_word_1_reset;
  logic [7:0] interrupt_request_register;
  logic [7:0] interrupt_mask;
  logic       special_mask_mode;
  logic       auto_eoi_config;
  logic       auto_rotate_mode;
  logic       ocw2_write;
  logic [7:0] ocw2_data;
  logic       interrupt_acknowledge_n;
  logic       interrupt_to_cpu;
  logic [7:0] clear_interrupt_request;
  logic       freeze;
  logic [7:0] in_service_register;
  logic [2:0] acknowledged_level;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  priority_resolver_in_service dut (
    .clock                              (clock),
    .write_initial_command_word_1_reset (write_initial_command_word_1_reset),
    .interrupt_request_register         (interrupt_request_register),
    .interrupt_mask                     (interrupt_mask),
    .special_mask_mode                  (special_mask_mode),
    .auto_eoi_config                    (auto_eoi_config),
    .auto_rotate_mode                   (auto_rotate_mode),
    .ocw2_write                         (ocw2_write),
    .ocw2_data                          (ocw2_data),
    .interrupt_acknowledge_n            (interrupt_acknowledge_n),
    .interrupt_to_cpu                   (interrupt_to_cpu),
    .clear_interrupt_request            (clear_interrupt_request),
    .freeze                             (freeze),
    .in_service_register                (in_service_register),
    .acknowledged_level                 (acknowledged_level)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pin_fall();
    interrupt_acknowledge_n = 1'b0;
    tick();
  endtask

  task automatic pin_rise();
    interrupt_acknowledge_n = 1'b1;
    tick();
  endtask

  task automatic ocw2(input logic [7:0] data);
    ocw2_write = 1'b1;
    ocw2_data  = data;
    tick();
    ocw2_write = 1'b0;
    ocw2_data  = 8'h00;
  endtask

  // Remaining rise / fall / rise of an INTA pair after the first fall.
  task automatic finish_pair();
    pin_rise();
    pin_fall();
    pin_rise();
  endtask

  initial begin
    write_initial_command_word_1_reset = 1'b1;
    interrupt_request_register = 8'h00;
    interrupt_mask             = 8'h00;
    special_mask_mode          = 1'b0;
    auto_eoi_config            = 1'b0;
    auto_rotate_mode           = 1'b0;
    ocw2_write                 = 1'b0;
    ocw2_data                  = 8'h00;
    interrupt_acknowledge_n    = 1'b1;
    tick();
    tick();
    check_eq("rst_int",    8'(interrupt_to_cpu), 8'h00);
    check_eq("rst_isr",    in_service_register, 8'h00);
    check_eq("rst_clear",  clear_interrupt_request, 8'h00);
    check_eq("rst_freeze", 8'(freeze), 8'h00);
    check_eq("rst_level",  8'(acknowledged_level), 8'h00);
    write_initial_command_word_1_reset = 1'b0;

    // Basic request and INTA pair
    interrupt_request_register = 8'h24;
    tick();
    check_eq("t1_int", 8'(interrupt_to_cpu), 8'h01);
    pin_fall();
    check_eq("t1_isr",    in_service_register, 8'h04);
    check_eq("t1_clear",  clear_interrupt_request, 8'h04);
    check_eq("t1_level",  8'(acknowledged_level), 8'h02);
    check_eq("t1_freeze", 8'(freeze), 8'h01);
    check_eq("t1_int_lo", 8'(interrupt_to_cpu), 8'h00);
    interrupt_request_register = 8'h00;
    pin_rise();
    check_eq("t1_clear_1cyc", clear_interrupt_request, 8'h00);
    check_eq("t1_freeze_gap", 8'(freeze), 8'h01);
    pin_fall();
    pin_rise();
    check_eq("t1_freeze_end", 8'(freeze), 8'h00);
    check_eq("t1_isr_end",    in_service_register, 8'h04);

    // Masking by in-service and special mask mode
    interrupt_request_register = 8'h20;
    tick();
    tick();
    check_eq("t2_blocked", 8'(interrupt_to_cpu), 8'h00);
    interrupt_request_register = 8'h02;
    tick();
    check_eq("t2_higher", 8'(interrupt_to_cpu), 8'h01);
    interrupt_request_register = 8'h20;
    special_mask_mode = 1'b1;
    tick();
    check_eq("t2_smm", 8'(interrupt_to_cpu), 8'h01);
    interrupt_request_register = 8'h10;
    tick();
    pin_fall();
    check_eq("t2_smm_level", 8'(acknowledged_level), 8'h04);
    check_eq("t2_smm_isr",   in_service_register, 8'h14);
    interrupt_request_register = 8'h00;
    special_mask_mode = 1'b0;
    finish_pair();

    // OCW2 EOI commands
    ocw2(8'h20);
    check_eq("t3_nseoi", in_service_register, 8'h10);
    ocw2(8'h64);
    check_eq("t3_seoi", in_service_register, 8'h00);
    ocw2(8'h20);
    check_eq("t3_nseoi_empty", in_service_register, 8'h00);

    // Set priority then rotate on specific EOI
    ocw2(8'hC4);
    interrupt_request_register = 8'h81;
    tick();
    check_eq("t4_int", 8'(interrupt_to_cpu), 8'h01);
    pin_fall();
    check_eq("t4_level", 8'(acknowledged_level), 8'h07);
    check_eq("t4_clear", clear_interrupt_request, 8'h80);
    interrupt_request_register = 8'h00;
    finish_pair();
    check_eq("t4_isr", in_service_register, 8'h80);
    ocw2(8'hE7);
    check_eq("t4_rseoi", in_service_register, 8'h00);
    interrupt_request_register = 8'h81;
    tick();
    pin_fall();
    check_eq("t4_lowest7", 8'(acknowledged_level), 8'h00);
    interrupt_request_register = 8'h00;
    finish_pair();
    ocw2(8'h60);
    check_eq("t4_clr0", in_service_register, 8'h00);

    // Auto-EOI with auto-rotate
    auto_eoi_config  = 1'b1;
    auto_rotate_mode = 1'b1;
    interrupt_request_register = 8'h08;
    tick();
    pin_fall();
    check_eq("t5_level",  8'(acknowledged_level), 8'h03);
    check_eq("t5_isr_in", in_service_register, 8'h08);
    interrupt_request_register = 8'h00;
    pin_rise();
    pin_fall();
    check_eq("t5_isr_ack2", in_service_register, 8'h08);
    pin_rise();
    check_eq("t5_isr_aeoi", in_service_register, 8'h00);
    interrupt_request_register = 8'h09;
    tick();
    pin_fall();
    check_eq("t5_rot_level", 8'(acknowledged_level), 8'h00);
    interrupt_request_register = 8'h00;
    finish_pair();
    check_eq("t5_isr_end", in_service_register, 8'h00);
    auto_eoi_config  = 1'b0;
    auto_rotate_mode = 1'b0;

    // Spurious acknowledge and reset mid-sequence
    interrupt_request_register = 8'h02;
    tick();
    check_eq("t6_int", 8'(interrupt_to_cpu), 8'h01);
    interrupt_request_register = 8'h00;
    pin_fall();
    check_eq("t6_level",  8'(acknowledged_level), 8'h07);
    check_eq("t6_isr",    in_service_register, 8'h00);
    check_eq("t6_clear",  clear_interrupt_request, 8'h00);
    check_eq("t6_int_lo", 8'(interrupt_to_cpu), 8'h00);
    pin_rise();
    check_eq("t6_gap_freeze", 8'(freeze), 8'h01);
    write_initial_command_word_1_reset = 1'b1;
    tick();
    check_eq("t6_rst_freeze", 8'(freeze), 8'h00);
    check_eq("t6_rst_int",    8'(interrupt_to_cpu), 8'h00);
    write_initial_command_word_1_reset = 1'b0;
    pin_fall();
    check_eq("t6_restart_freeze", 8'(freeze), 8'h01);
    pin_rise();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
